read_id: RTL and testbench

READ_ID -- requirements
Module: read_id

---
 rtl/read_id.sv | 121 ++++++++++++
 tb/tb_read_id.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/read_id.sv
// NAND flash Read-ID sequencer: issues the Read-ID command and address cycle,
// waits tWHR, then strobes RE_n four times and keeps the device ID byte.
module read_id #(
  parameter logic [7:0] CMD_READID   = 8'h90,
  parameter int         DUMMY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ctrl_in_data,
  input  logic [7:0] nandIOin,
  output logic [7:0] TonandIO,
  output logic [4:0] outputVEC_tb,
  output logic       toggleDone_tb,
  output logic       IDread_done,
  output logic       dummy_cnt_tb,
  output logic [1:0] state_reg_tb,
  output logic [1:0] IDread_cnt_tb,
  output logic [7:0] DevID_tb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ADDR = 2'd2,
    READ = 2'd3
  } state_t;

  localparam logic DUMMY_LAST = 1'(DUMMY_CYCLES - 1);

  state_t     state, next_state;
  logic [1:0] phase;
  logic       armed;
  logic       dummy_cnt;
  logic       dummy_done;
  logic [1:0] id_cnt;
  logic [7:0] dev_id;
  logic       id_done;

  logic start;
  logic toggling;
  logic toggle_done;
  logic strobe;

  // The strobe generator only runs once the tWHR wait in READ has elapsed.
  always_comb begin
    start       = (state == IDLE) && (ctrl_in_data == CMD_READID) && armed;
    toggling    = (state == CMD) || (state == ADDR) || ((state == READ) && dummy_done);
    toggle_done = toggling && (phase == 2'd3);
    strobe      = phase[1];
    next_state  = state;
    case (state)
      IDLE: if (start) next_state = CMD;
      CMD:  if (toggle_done) next_state = ADDR;
      ADDR: if (toggle_done) next_state = READ;
      READ: if (toggle_done && (id_cnt == 2'd3)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pin order is {CLE, ALE, CE_n, WE_n, RE_n}.
  always_comb begin
    TonandIO     = 8'h00;
    outputVEC_tb = 5'b00111;
    case (state)
      CMD: begin
        TonandIO     = CMD_READID;
        outputVEC_tb = {1'b1, 1'b0, 1'b0, strobe, 1'b1};
      end
      ADDR: outputVEC_tb = {1'b0, 1'b1, 1'b0, strobe, 1'b1};
      READ: outputVEC_tb = {1'b0, 1'b0, 1'b0, 1'b1, (dummy_done ? strobe : 1'b1)};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= 2'd0;
      armed      <= 1'b1;
      dummy_cnt  <= 1'b0;
      dummy_done <= 1'b0;
      id_cnt     <= 2'd0;
      dev_id     <= 8'h00;
      id_done    <= 1'b0;
    end else begin
      state <= next_state;

      if ((next_state != state) || !toggling) phase <= 2'd0;
      else phase <= phase + 2'd1;

      // Re-arming needs the opcode to go away, so a held opcode runs once.
      if (start) armed <= 1'b0;
      else if ((state == IDLE) && (ctrl_in_data != CMD_READID)) armed <= 1'b1;

      if (start) id_done <= 1'b0;
      else if ((state == READ) && (next_state == IDLE)) id_done <= 1'b1;

      if (state != READ) begin
        dummy_cnt  <= 1'b0;
        dummy_done <= 1'b0;
      end else if (!dummy_done) begin
        if (dummy_cnt == DUMMY_LAST) dummy_done <= 1'b1;
        else dummy_cnt <= dummy_cnt + 1'b1;
      end

      if ((state == READ) && toggle_done) id_cnt <= id_cnt + 2'd1;

      // Sample just before RE_n rises; only the device-ID byte is kept.
      if ((state == READ) && toggling && (phase == 2'd1) && (id_cnt == 2'd1))
        dev_id <= nandIOin;
    end
  end

  assign toggleDone_tb = toggle_done;
  assign IDread_done   = id_done;
  assign dummy_cnt_tb  = dummy_cnt;
  assign state_reg_tb  = state;
  assign IDread_cnt_tb = id_cnt;
  assign DevID_tb      = dev_id;

endmodule

// File: tb/tb_read_id.sv
// Directed bench for read_id: reset values, full Read-ID sequences, re-arm
// behaviour, ignored opcodes and reset in the middle of a sequence.
module tb_read_id;

  logic       clk;
  logic       reset;
  logic [7:0] ctrl_in_data;
  logic [7:0] nandIOin;
  logic [7:0] TonandIO;
  logic [4:0] outputVEC_tb;
  logic       toggleDone_tb;
  logic       IDread_done;
  logic       dummy_cnt_tb;
  logic [1:0] state_reg_tb;
  logic [1:0] IDread_cnt_tb;
  logic [7:0] DevID_tb;

  int checkCount = 0;
  int failCount  = 0;

  read_id dut (
    .clk           (clk),
    .reset         (reset),
    .ctrl_in_data  (ctrl_in_data),
    .nandIOin      (nandIOin),
    .TonandIO      (TonandIO),
    .outputVEC_tb  (outputVEC_tb),
    .toggleDone_tb (toggleDone_tb),
    .IDread_done   (IDread_done),
    .dummy_cnt_tb  (dummy_cnt_tb),
    .state_reg_tb  (state_reg_tb),
    .IDread_cnt_tb (IDread_cnt_tb),
    .DevID_tb      (DevID_tb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic [7:0] ctrl, input logic [7:0] nand_data);
    reset        = rst;
    ctrl_in_data = ctrl;
    nandIOin     = nand_data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one sequence from the next rising edge; ids holds bytes 0..3 MSB first.
  task automatic runSequence(input logic [31:0] ids, input logic [7:0] mid_ctrl, input logic [7:0] exp_devid);
    int         cycles;
    int         we_low;
    int         re_falls;
    int         td_count;
    int         re_lead;
    logic       prev_re;
    logic [1:0] prev_state;
    logic [7:0] seq;
    cycles     = -1;
    we_low     = 0;
    re_falls   = 0;
    td_count   = 0;
    re_lead    = 0;
    prev_re    = 1'b1;
    prev_state = 2'd0;
    seq        = 8'h00;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput("start_state", {30'd0, state_reg_tb}, 32'd1);
        checkOutput("start_done_clear", {31'd0, IDread_done}, 32'd0);
        checkOutput("cmd_bus", {24'd0, TonandIO}, 32'h90);
      end
      if (k == 5) ctrl_in_data = mid_ctrl;
      if (state_reg_tb != prev_state) begin
        seq        = {seq[5:0], state_reg_tb};
        prev_state = state_reg_tb;
      end
      if (!outputVEC_tb[1]) we_low++;
      if ((state_reg_tb == 2'd3) && (re_falls == 0) && outputVEC_tb[0]) re_lead++;
      if (prev_re && !outputVEC_tb[0]) begin
        if (re_falls < 4) nandIOin = ids[(31 - 8 * re_falls) -: 8];
        re_falls++;
      end
      prev_re = outputVEC_tb[0];
      if (toggleDone_tb) td_count++;
      if (IDread_done) begin
        cycles = k;
        break;
      end
    end
    checkOutput("seq_cycles", cycles, 32'd26);
    checkOutput("state_order", {24'd0, seq}, 32'h6C);
    checkOutput("we_low_cycles", we_low, 32'd4);
    checkOutput("re_pulses", re_falls, 32'd4);
    checkOutput("twhr_lead", re_lead, 32'd2);
    checkOutput("toggle_done_pulses", td_count, 32'd6);
    checkOutput("devid", {24'd0, DevID_tb}, {24'd0, exp_devid});
    checkOutput("id_cnt_wrap", {30'd0, IDread_cnt_tb}, 32'd0);
    checkOutput("end_vec", {27'd0, outputVEC_tb}, 32'h07);
  endtask

  initial begin
    int non_idle;
    int re_falls;
    logic prev_re;

    applyStimulus(1'b0, 8'h90, 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("rst_state", {30'd0, state_reg_tb}, 32'd0);
    checkOutput("rst_vec", {27'd0, outputVEC_tb}, 32'h07);
    checkOutput("rst_bus", {24'd0, TonandIO}, 32'h00);
    checkOutput("rst_done", {31'd0, IDread_done}, 32'd0);
    checkOutput("rst_devid", {24'd0, DevID_tb}, 32'h00);
    checkOutput("rst_id_cnt", {30'd0, IDread_cnt_tb}, 32'd0);
    checkOutput("rst_dummy", {31'd0, dummy_cnt_tb}, 32'd0);
    checkOutput("rst_toggle_done", {31'd0, toggleDone_tb}, 32'd0);

    applyStimulus(1'b1, 8'h90, 8'hFF);
    runSequence(32'hFFFF_FFFF, 8'h90, 8'hFF);

    // Opcode held after completion must not retrigger.
    non_idle = 0;
    repeat (10) begin
      @(negedge clk);
      if ((state_reg_tb != 2'd0) || (outputVEC_tb != 5'b00111)) non_idle++;
    end
    checkOutput("held_no_restart", non_idle, 32'd0);
    checkOutput("held_done_stays", {31'd0, IDread_done}, 32'd1);

    applyStimulus(1'b1, 8'h00, 8'h00);
    @(negedge clk);
    applyStimulus(1'b1, 8'h90, 8'h00);
    runSequence(32'hECDA_1095, 8'hFF, 8'hDA);

    // Foreign opcode in IDLE: no activity, ID retained.
    non_idle = 0;
    repeat (10) begin
      @(negedge clk);
      if ((state_reg_tb != 2'd0) || (outputVEC_tb != 5'b00111) || toggleDone_tb) non_idle++;
    end
    checkOutput("ff_stays_idle", non_idle, 32'd0);
    checkOutput("devid_retained", {24'd0, DevID_tb}, 32'hDA);

    applyStimulus(1'b1, 8'h90, 8'h00);
    re_falls = 0;
    prev_re  = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (prev_re && !outputVEC_tb[0]) re_falls++;
      prev_re = outputVEC_tb[0];
      if (re_falls == 3) break;
    end
    checkOutput("reached_byte2", re_falls, 32'd3);
    checkOutput("byte2_state", {30'd0, state_reg_tb}, 32'd3);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_state", {30'd0, state_reg_tb}, 32'd0);
    checkOutput("midrst_vec", {27'd0, outputVEC_tb}, 32'h07);
    checkOutput("midrst_done", {31'd0, IDread_done}, 32'd0);
    checkOutput("midrst_id_cnt", {30'd0, IDread_cnt_tb}, 32'd0);
    checkOutput("midrst_devid", {24'd0, DevID_tb}, 32'h00);
    reset = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
